// File: rtl/tlm_sb_pkg.sv
// Shared types and parameter defaults/limits for the sideband RX queue.
package tlm_sb_pkg;

    // Message class of a sideband flit
    typedef enum logic {
        SB_PC = 1'b0,
        SB_NP = 1'b1
    } sb_class_e;

    // Credit FSM states
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

    localparam int PAYLOAD_W_DEF = 8;
    localparam int SLOTS_DEF     = 2;
    localparam int SLOTS_MIN     = 1;
    localparam int SLOTS_MAX     = 8;
    localparam int MAX_FLITS_DEF = 4;

    // Flits each class FIFO must hold so every advertised credit can be filled
    function automatic int fifo_depth(input int slots, input int max_flits);
        return slots * max_flits;
    endfunction

endpackage

// File: rtl/tlm_sb_flit_fifo.sv
// Single-clock flit FIFO. A write is visible on the output the cycle after
// it is accepted; a read in the same cycle frees the head entry first, so a
// write into a full FIFO succeeds when it is paired with a read.
module tlm_sb_flit_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             vld,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rd_fire;
    logic             wr_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vld     = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_fire = rd_en & vld;
    assign wr_fire = wr_en & (~full | rd_fire);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tlm_sb_rx_queue.sv
// Sideband RX queue: per-class flit FIFOs (posted/completion and non-posted)
// with a credit FSM that advertises SLOTS message credits after reset and
// returns one credit per dequeued end-of-message flit.
// Optional protocol checking is compiled in with TLM_SB_RX_PROTO_CHK_EN.
//
// state | meaning
// INIT  | advertising initial credits, one pulse per class per cycle
// RUN   | credits advertised; cups follow eom dequeues
module tlm_sb_rx_queue
    import tlm_sb_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int SLOTS     = SLOTS_DEF,
    parameter int MAX_FLITS = MAX_FLITS_DEF
) (
    input  logic                 tlm_secondary_clock,
    input  logic                 tlm_secondary_reset,
    input  logic                 sb2_tlm_pcput,
    input  logic                 sb2_tlm_npput,
    input  logic                 sb2_tlm_eom,
    input  logic [PAYLOAD_W-1:0] sb2_tlm_payload,
    output logic                 tlm_sb2_pccup,
    output logic                 tlm_sb2_npcup,
    output logic                 pc_vld,
    output logic [PAYLOAD_W-1:0] pc_data,
    output logic                 pc_eom,
    input  logic                 pc_rdy,
    output logic                 np_vld,
    output logic [PAYLOAD_W-1:0] np_data,
    output logic                 np_eom,
    input  logic                 np_rdy,
    output logic                 init_done,
    output logic                 err_proto
);

    localparam int DEPTH  = fifo_depth(SLOTS, MAX_FLITS);
    localparam int ICNT_W = $clog2(SLOTS + 1);

    logic                 pc_wr;
    logic                 np_wr;
    logic                 pc_fifo_vld;
    logic                 np_fifo_vld;
    logic                 pc_full;
    logic                 np_full;
    logic [PAYLOAD_W:0]   pc_head;
    logic [PAYLOAD_W:0]   np_head;
    logic                 pc_fire;
    logic                 np_fire;
    rx_state_e            state;
    logic [ICNT_W-1:0]    init_cnt;

    tlm_sb_flit_fifo #(
        .WIDTH (PAYLOAD_W + 1),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (tlm_secondary_clock),
        .rst     (tlm_secondary_reset),
        .wr_en   (pc_wr),
        .wr_data ({sb2_tlm_eom, sb2_tlm_payload}),
        .rd_en   (pc_rdy),
        .rd_data (pc_head),
        .vld     (pc_fifo_vld),
        .full    (pc_full)
    );

    tlm_sb_flit_fifo #(
        .WIDTH (PAYLOAD_W + 1),
        .DEPTH (DEPTH)
    ) u_np_fifo (
        .clk     (tlm_secondary_clock),
        .rst     (tlm_secondary_reset),
        .wr_en   (np_wr),
        .wr_data ({sb2_tlm_eom, sb2_tlm_payload}),
        .rd_en   (np_rdy),
        .rd_data (np_head),
        .vld     (np_fifo_vld),
        .full    (np_full)
    );

    // Outputs are forced low while reset is held, including the first reset cycle
    assign pc_vld  = pc_fifo_vld & ~tlm_secondary_reset;
    assign np_vld  = np_fifo_vld & ~tlm_secondary_reset;
    assign pc_data = pc_vld ? pc_head[PAYLOAD_W-1:0] : '0;
    assign np_data = np_vld ? np_head[PAYLOAD_W-1:0] : '0;
    assign pc_eom  = pc_vld & pc_head[PAYLOAD_W];
    assign np_eom  = np_vld & np_head[PAYLOAD_W];
    assign pc_fire = pc_vld & pc_rdy;
    assign np_fire = np_vld & np_rdy;

    // Credit FSM: SLOTS initial pulses, then one cup per dequeued eom per class
    always_ff @(posedge tlm_secondary_clock) begin
        if (tlm_secondary_reset) begin
            state         <= INIT;
            init_cnt      <= ICNT_W'(SLOTS);
            init_done     <= 1'b0;
            tlm_sb2_pccup <= 1'b0;
            tlm_sb2_npcup <= 1'b0;
        end else begin
            tlm_sb2_pccup <= pc_fire & pc_eom;
            tlm_sb2_npcup <= np_fire & np_eom;
            case (state)
                INIT: begin
                    tlm_sb2_pccup <= 1'b1;
                    tlm_sb2_npcup <= 1'b1;
                    init_cnt      <= init_cnt - 1'b1;
                    if (init_cnt == ICNT_W'(1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef TLM_SB_RX_PROTO_CHK_EN
    localparam int FCNT_W = $clog2(MAX_FLITS + 1);
    localparam int MCNT_W = $clog2(SLOTS + 2);

    logic              both_put;
    logic              pc_acc;
    logic              np_acc;
    logic              pc_ovf;
    logic              np_ovf;
    logic              pc_long;
    logic              np_long;
    logic              pc_msg_err;
    logic              np_msg_err;
    logic [FCNT_W-1:0] pc_flits;
    logic [FCNT_W-1:0] np_flits;
    logic [MCNT_W-1:0] pc_msgs;
    logic [MCNT_W-1:0] np_msgs;

    // Simultaneous puts are ambiguous, so both flits are discarded
    assign both_put = sb2_tlm_pcput & sb2_tlm_npput;
    assign pc_wr    = sb2_tlm_pcput & ~sb2_tlm_npput;
    assign np_wr    = sb2_tlm_npput & ~sb2_tlm_pcput;
    assign pc_acc   = pc_wr & (~pc_full | pc_fire);
    assign np_acc   = np_wr & (~np_full | np_fire);
    assign pc_ovf   = sb2_tlm_pcput & pc_full & ~pc_fire;
    assign np_ovf   = sb2_tlm_npput & np_full & ~np_fire;
    assign pc_long  = pc_acc & ~sb2_tlm_eom & (pc_flits == FCNT_W'(MAX_FLITS - 1));
    assign np_long  = np_acc & ~sb2_tlm_eom & (np_flits == FCNT_W'(MAX_FLITS - 1));
    // Outstanding messages are those whose eom is queued but not yet consumed
    assign pc_msg_err = pc_acc & sb2_tlm_eom & ~(pc_fire & pc_eom) &
                        (pc_msgs >= MCNT_W'(SLOTS));
    assign np_msg_err = np_acc & sb2_tlm_eom & ~(np_fire & np_eom) &
                        (np_msgs >= MCNT_W'(SLOTS));

    // Per-class flit-in-message and complete-message counters
    always_ff @(posedge tlm_secondary_clock) begin
        if (tlm_secondary_reset) begin
            pc_flits <= '0;
            np_flits <= '0;
            pc_msgs  <= '0;
            np_msgs  <= '0;
        end else begin
            if (pc_acc) begin
                if (sb2_tlm_eom) begin
                    pc_flits <= '0;
                end else if (pc_flits != FCNT_W'(MAX_FLITS - 1)) begin
                    pc_flits <= pc_flits + 1'b1;
                end
            end
            if (np_acc) begin
                if (sb2_tlm_eom) begin
                    np_flits <= '0;
                end else if (np_flits != FCNT_W'(MAX_FLITS - 1)) begin
                    np_flits <= np_flits + 1'b1;
                end
            end
            case ({pc_acc & sb2_tlm_eom, pc_fire & pc_eom})
                2'b10:   if (pc_msgs != MCNT_W'(SLOTS + 1)) pc_msgs <= pc_msgs + 1'b1;
                2'b01:   if (pc_msgs != '0) pc_msgs <= pc_msgs - 1'b1;
                default: pc_msgs <= pc_msgs;
            endcase
            case ({np_acc & sb2_tlm_eom, np_fire & np_eom})
                2'b10:   if (np_msgs != MCNT_W'(SLOTS + 1)) np_msgs <= np_msgs + 1'b1;
                2'b01:   if (np_msgs != '0) np_msgs <= np_msgs - 1'b1;
                default: np_msgs <= np_msgs;
            endcase
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge tlm_secondary_clock) begin
        if (tlm_secondary_reset) begin
            err_proto <= 1'b0;
        end else if (both_put | pc_ovf | np_ovf | pc_long | np_long |
                     pc_msg_err | np_msg_err) begin
            err_proto <= 1'b1;
        end
    end
`else
    logic unused_full;

    assign pc_wr       = sb2_tlm_pcput;
    assign np_wr       = sb2_tlm_npput;
    assign err_proto   = 1'b0;
    assign unused_full = pc_full ^ np_full;
`endif

endmodule
